// File: rtl/hd_stim_src_pkg.sv
// Shared definitions for the Hamming-encoder stimulus source.
//   DATA_W_DEF / CNT_W_DEF : default data word and word-count widths
//   LFSR_SEED_DEF          : default non-zero LFSR start state
//   LFSR_MASK              : Galois feedback mask of the 16-bit LFSR
//   state_t                : stimulus FSM state encoding
//   lfsr_step()            : one Galois LFSR step
package hd_stim_src_pkg;

  localparam int          DATA_W_DEF    = 4;
  localparam int          CNT_W_DEF     = 16;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  localparam logic [15:0] LFSR_MASK     = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Shift right and fold the mask in when a one falls out of bit 0.
  // A non-zero state can never map to zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/hd_stim_src_lfsr16.sv
// 16-bit Galois LFSR used as the pseudo-random word generator.
// Ports:
//   clk     : clock, posedge
//   rst     : synchronous active-high reset, returns the state to SEED
//   load    : reload SEED (takes priority over advance)
//   advance : step the LFSR once
//   word    : low OUT_W bits of the current LFSR state
module hd_lfsr16
  import hd_stim_src_pkg::*;
#(
  parameter logic [15:0] SEED  = LFSR_SEED_DEF,
  parameter int          OUT_W = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [OUT_W-1:0] word
);

  logic [15:0] lfsr_reg;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      lfsr_reg <= SEED;
    end else if (advance) begin
      lfsr_reg <= lfsr_step(lfsr_reg);
    end
  end

  assign word = lfsr_reg[OUT_W-1:0];

endmodule

// File: rtl/hd_stim_src.sv
// Stimulus source for the Hamming encoder bench. On a start request in IDLE
// it emits num_words data words over a valid/ready handshake, either as an
// incrementing count or as the low bits of a 16-bit Galois LFSR.
// Ports:
//   clk, rst   : clock (posedge) and synchronous active-high reset
//   start      : start request, only looked at in IDLE
//   mode       : 0 = incrementing, 1 = LFSR; latched on start
//   num_words  : words to emit; latched on start (0 gives an empty run)
//   out_data   : word presented to the encoder
//   out_valid  : out_data is valid
//   out_ready  : encoder accepts the word
//   busy       : high while words are being emitted
//   done       : one-cycle pulse when a run completes
//   word_cnt   : words accepted in the current or last run
module hd_stim_src
  import hd_stim_src_pkg::*;
#(
  parameter int          DATA_W    = DATA_W_DEF,
  parameter int          CNT_W     = CNT_W_DEF,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [CNT_W-1:0]  num_words,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  word_cnt
);

  state_t              state_reg;
  logic                mode_reg;
  logic [CNT_W-1:0]    num_reg;
  logic [DATA_W-1:0]   inc_reg;
  logic                out_valid_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [CNT_W-1:0]    word_cnt_reg;
  logic [DATA_W-1:0]   lfsr_word;

  logic                start_ok;
  logic                xfer;
  logic                last_xfer;

  assign start_ok = (state_reg == ST_IDLE) && start;
  assign xfer     = (state_reg == ST_RUN) && out_valid_reg && out_ready;
  // Compare one bit wider so a full-scale num_words never wraps.
  assign last_xfer = ({1'b0, word_cnt_reg} + 1'b1) == {1'b0, num_reg};

  hd_lfsr16 #(
    .SEED  (LFSR_SEED),
    .OUT_W (DATA_W)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (start_ok),
    .advance (xfer),
    .word    (lfsr_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      mode_reg      <= 1'b0;
      num_reg       <= '0;
      inc_reg       <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      word_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            mode_reg     <= mode;
            num_reg      <= num_words;
            word_cnt_reg <= '0;
            inc_reg      <= '0;
            if (num_words == '0) begin
              state_reg     <= ST_DONE;
              done_reg      <= 1'b1;
              busy_reg      <= 1'b0;
              out_valid_reg <= 1'b0;
            end else begin
              state_reg     <= ST_RUN;
              busy_reg      <= 1'b1;
              out_valid_reg <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (xfer) begin
            word_cnt_reg <= word_cnt_reg + 1'b1;
            inc_reg      <= inc_reg + 1'b1;
            if (last_xfer) begin
              state_reg     <= ST_DONE;
              out_valid_reg <= 1'b0;
              busy_reg      <= 1'b0;
              done_reg      <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg     <= ST_IDLE;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          done_reg      <= 1'b0;
        end
      endcase
    end
  end

  // Both generators are registers that only move on a transfer or a start,
  // so the selected word is stable for as long as the encoder stalls.
  assign out_data  = mode_reg ? lfsr_word : inc_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign word_cnt  = word_cnt_reg;

endmodule

// File: tb/tb_hd_stim_src.sv
module tb_hd_stim_src;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] num_words = '0;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [15:0] word_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hd_stim_src dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .num_words (num_words),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .word_cnt  (word_cnt)
  );

  typedef struct packed {
    logic        mode;
    logic [15:0] num;
    logic [71:0] exp;   // expected word i in bits [i*4 +: 4]
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [15:0] cnt);
    chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " busy"},      {31'd0, busy},      32'd0);
    chk({tag, " done"},      {31'd0, done},      32'd0);
    chk({tag, " word_cnt"},  {16'd0, word_cnt},  {16'd0, cnt});
  endtask

  // Start a run with ready held high and check every word plus the done pulse.
  task automatic run_stream(input int vi);
    vec_t v;
    v = vecs[vi];
    out_ready = 1'b1;
    mode      = v.mode;
    num_words = v.num;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    num_words = 16'd2;   // must be ignored mid-run
    mode      = ~v.mode;
    for (int i = 0; i < int'(v.num); i++) begin
      chk($sformatf("v%0d w%0d out_valid", vi, i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d w%0d out_data", vi, i), {28'd0, out_data}, {28'd0, v.exp[i*4 +: 4]});
      chk($sformatf("v%0d w%0d busy", vi, i), {31'd0, busy}, 32'd1);
      $display("[TB] vec %0d word %0d data=%0h", vi, i, out_data);
      tick();
    end
    chk($sformatf("v%0d done", vi), {31'd0, done}, 32'd1);
    chk($sformatf("v%0d end out_valid", vi), {31'd0, out_valid}, 32'd0);
    chk($sformatf("v%0d word_cnt", vi), {16'd0, word_cnt}, {16'd0, v.num});
    tick();
    chk_idle($sformatf("v%0d after", vi), v.num);
  endtask

  initial begin
    // mode, num_words, expected words (index 0 in the low nibble)
    vecs[0] = '{mode: 1'b0, num: 16'd18, exp: 72'h10FEDCBA9876543210};
    vecs[1] = '{mode: 1'b1, num: 16'd3,  exp: 72'h000000000000000801};
    vecs[2] = '{mode: 1'b1, num: 16'd6,  exp: 72'h0000000000007EC801};
    vecs[3] = '{mode: 1'b0, num: 16'd1,  exp: 72'h000000000000000000};

    // Reset held for 4 cycles, then quiet idle.
    rst = 1'b1;
    repeat (4) begin
      tick();
      chk_idle("reset", 16'd0);
    end
    rst = 1'b0;
    repeat (3) begin
      tick();
      chk_idle("post-reset", 16'd0);
      chk("post-reset out_data", {28'd0, out_data}, 32'd0);
    end

    for (int vi = 0; vi < 4; vi++) run_stream(vi);

    // Backpressure: ready low on RUN cycles 2..4; start pokes while busy.
    begin
      int exp_idx = 0;
      int cyc = 0;
      mode = 1'b0; num_words = 16'd4; start = 1'b1;
      tick();
      start = 1'b0;
      while (exp_idx < 4 && cyc < 20) begin
        cyc++;
        out_ready = !(cyc >= 2 && cyc <= 4);
        start     = (cyc >= 2 && cyc <= 4);
        num_words = 16'd1;
        chk($sformatf("bp c%0d out_valid", cyc), {31'd0, out_valid}, 32'd1);
        chk($sformatf("bp c%0d out_data", cyc), {28'd0, out_data}, exp_idx);
        $display("[TB] backpressure cycle %0d data=%0h ready=%0b", cyc, out_data, out_ready);
        if (out_ready) exp_idx++;
        tick();
      end
      start = 1'b0; out_ready = 1'b1;
      chk("bp completed in budget", {31'd0, exp_idx == 4}, 32'd1);
      chk("bp done", {31'd0, done}, 32'd1);
      chk("bp word_cnt", {16'd0, word_cnt}, 32'd4);
      tick();
      chk_idle("bp after", 16'd4);
    end

    // Zero length: done on the cycle after start, no valid.
    mode = 1'b0; num_words = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero done", {31'd0, done}, 32'd1);
    chk("zero out_valid", {31'd0, out_valid}, 32'd0);
    chk("zero busy", {31'd0, busy}, 32'd0);
    chk("zero word_cnt", {16'd0, word_cnt}, 32'd0);
    $display("[TB] zero-length run done=%0b", done);
    tick();
    chk_idle("zero after", 16'd0);

    // Reset mid-run after 5 LFSR transfers.
    mode = 1'b1; num_words = 16'd10; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [19:0] lw;
      lw = 20'hEC801;
      chk($sformatf("mid w%0d out_data", i), {28'd0, out_data}, {28'd0, lw[i*4 +: 4]});
      tick();
    end
    chk("mid word_cnt before rst", {16'd0, word_cnt}, 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("mid rst", 16'd0);
    chk("mid rst out_data", {28'd0, out_data}, 32'd0);
    $display("[TB] reset mid-run out_valid=%0b word_cnt=%0d", out_valid, word_cnt);
    repeat (3) begin
      tick();
      chk_idle("mid rst quiet", 16'd0);
    end
    run_stream(1);

    // Start held: a new run begins the cycle after DONE returns to IDLE.
    mode = 1'b0; num_words = 16'd1; start = 1'b1;
    tick();
    chk("held run1 valid", {31'd0, out_valid}, 32'd1);
    tick();
    chk("held run1 done", {31'd0, done}, 32'd1);
    chk("held run1 cnt", {16'd0, word_cnt}, 32'd1);
    tick();
    chk_idle("held idle", 16'd1);
    tick();
    chk("held run2 valid", {31'd0, out_valid}, 32'd1);
    chk("held run2 busy", {31'd0, busy}, 32'd1);
    chk("held run2 cnt", {16'd0, word_cnt}, 32'd0);
    chk("held run2 data", {28'd0, out_data}, 32'd0);
    $display("[TB] held start second run valid=%0b", out_valid);
    start = 1'b0;
    tick();
    chk("held run2 done", {31'd0, done}, 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hd_stim_src.md
Name: hd_stim_src

Overview:
- Synthesizable stimulus source for the Hamming encoder bench. Sits directly downstream of the clock/reset controller and directly upstream of the encoder.
- Consumes the bench clock and a synchronous active-high reset. At the bench top level, reset is the inverse of the controller's active-low reset output.
- On a start request, emits a programmed number of data words over a valid/ready handshake into the encoder input.
- Word sequence is either incrementing or pseudo-random (LFSR).

Parameters:
- DATA_W, 4, data word width fed to the encoder (Hamming(7,4) default).
- CNT_W, 16, width of the word-count fields.
- LFSR_SEED, 16'hACE1, initial 16-bit LFSR state; must be non-zero.

Ports:
- clk  input  1  bench clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  start request; sampled only in IDLE.
- mode  input  1  0 = incrementing data, 1 = LFSR data; latched on start.
- num_words  input  CNT_W  number of words to emit; latched on start.
- out_data  output  DATA_W  word presented to the encoder.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  encoder accepts the word.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the sequence completes.
- word_cnt  output  CNT_W  number of words accepted in the current or last run.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values (registered):
  - state = IDLE; out_valid = 0; out_data = 0; busy = 0; done = 0; word_cnt = 0.
  - Internal incrementer = 0; LFSR = LFSR_SEED.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start = 1 latches mode and num_words, clears word_cnt, and reloads the generators (incrementer = 0, LFSR = LFSR_SEED).
  - If num_words = 0, go to DONE. Otherwise go to RUN.
- RUN:
  - out_valid = 1 from the first RUN cycle; one cycle of latency after start.
  - First word: incr mode = 0; LFSR mode = LFSR_SEED[DATA_W-1:0].
  - Transfer occurs when out_valid && out_ready at a posedge. On each transfer:
    - word_cnt += 1.
    - Generator advances; the next word appears the following cycle, giving back-to-back throughput of one word per cycle.
  - While out_ready = 0: out_data and out_valid hold stable (no retraction, no change).
  - On the transfer where word_cnt + 1 == latched num_words, go to DONE; out_valid = 0 next cycle.
- DONE: done = 1 for exactly one cycle, busy = 0, then IDLE. word_cnt holds its final value until the next start.
- Incrementing mode: out_data = incrementer[DATA_W-1:0], wrapping modulo 2^DATA_W (e.g. 4'hF -> 4'h0).
- LFSR mode:
  - 16-bit Galois LFSR, mask 16'hB400: next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0).
  - out_data = lfsr[DATA_W-1:0]. The LFSR never reaches 0.
- Boundary conditions:
  - start while in RUN or DONE: ignored; num_words/mode changes mid-run have no effect.
  - out_ready high while out_valid low: no effect.
  - num_words = 2^CNT_W - 1: runs to completion with no counter overflow.
  - rst mid-RUN: next cycle all outputs are at reset values, any in-flight word is dropped, and no done pulse is generated.
  - start held continuously: a new run begins on the cycle after DONE returns to IDLE.

Decomposition:
- Shared package/include (alongside the existing bench parameters): DATA_W, CNT_W, LFSR_SEED, LFSR mask 16'hB400, FSM state encodings.
- One natural sub-module: hd_lfsr16, with load, advance and state output. The incrementer stays inline.

Test Plan:
- Reset: hold rst = 1 for 4 cycles, then release -> out_valid = 0, busy = 0, done = 0, word_cnt = 0 throughout, and nothing changes until start.
- Incrementing, ready always 1: mode = 0, num_words = 18 -> out_data 0,1,...,F,0,1 on consecutive cycles; done pulses one cycle after the last transfer; word_cnt = 18.
- LFSR, ready always 1: mode = 1, num_words = 3 -> out_data 4'h1, 4'h0, 4'h8 (LFSR states ACE1, E270, 7138); done pulses once.
- Backpressure: mode = 0, num_words = 4; out_ready low on cycles 2–4 of RUN -> out_data/out_valid stable while stalled, sequence 0,1,2,3 with no loss or duplication, word_cnt = 4.
- Zero length: num_words = 0 with start -> out_valid never asserts; done pulses on the cycle after start, then IDLE.
- Reset mid-run: mode = 1, num_words = 10, assert rst after 5 transfers -> outputs go to reset values next cycle with no done pulse; a fresh start restarts the sequence at 4'h1.
